// File: rtl/seg_7_reader_pkg.sv
// Shared definitions for the seven-segment reader: glyph patterns (bit 6 = a ... bit 0 = g),
// FSM state encoding and the default settle length.
package seg_7_reader_pkg;

  localparam int unsigned STABLE_CYCLES_DEFAULT = 4;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    PEND   = 2'd2
  } state_e;

endpackage

// File: rtl/seg_7_decode.sv
// Combinational glyph-to-value decoder. Hex letters A..F decode as legal only when
// SEG7_HEX_EN is defined; otherwise they fall through to err = 1, digit = 0.
module seg_7_decode
  import seg_7_reader_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] digit_o,
  output logic       err_o
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    digit_o = 4'd0;
    err_o   = 1'b0;
    unique case (pattern_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
`ifdef SEG7_HEX_EN
      SEG_A:   digit_o = 4'd10;
      SEG_B:   digit_o = 4'd11;
      SEG_C:   digit_o = 4'd12;
      SEG_D:   digit_o = 4'd13;
      SEG_E:   digit_o = 4'd14;
      SEG_F:   digit_o = 4'd15;
`endif
      default: err_o   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_7_reader.sv
// Debounced seven-segment reader: synchronizes seg_7, waits for STABLE_CYCLES identical
// samples, reports each new non-blank glyph once via a valid/ready handshake.
// Optional hex glyphs are enabled in seg_7_decode by SEG7_HEX_EN.
module seg_7_reader
  import seg_7_reader_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_7,
  input  logic       out_ready,
  input  logic       overrun_clr,
  output logic [3:0] digit,
  output logic       out_valid,
  output logic       err,
  output logic       overrun
);

  localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

  logic [6:0] s1_q, s2_q;
  logic [6:0] cand_q, cand_d;
  logic [6:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] digit_q, digit_d;
  logic       err_q, err_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
  logic       overrun_set;
  state_e     state_q, state_d;

  logic [3:0] dec_digit;
  logic       dec_err;

  seg_7_decode u_decode (
    .pattern_i (cand_q),
    .digit_o   (dec_digit),
    .err_o     (dec_err)
  );

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    digit_d     = digit_q;
    err_d       = err_q;
    valid_d     = valid_q;
    overrun_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s2_q != last_q) begin
          cand_d  = s2_q;
          cnt_d   = 8'd1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // A return to the last reported glyph is a glitch, not a new candidate.
        if (s2_q == last_q) begin
          state_d = IDLE;
        end else if (s2_q != cand_q) begin
          cand_d = s2_q;
          cnt_d  = 8'd1;
        end else if (cnt_q == STABLE_CNT) begin
          last_d = cand_q;
          if (cand_q == SEG_BLANK) begin
            state_d = IDLE;
          end else begin
            digit_d = dec_digit;
            err_d   = dec_err;
            valid_d = 1'b1;
            state_d = PEND;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PEND: begin
        overrun_set = (s2_q != last_q);
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Set wins over clear so a change during the clear cycle is never lost.
    overrun_d = overrun_set | (overrun_q & ~overrun_clr);
  end

  // NOTE: sequential state uses non-blocking assignments; every register here is small
  // control/data state, so all of it takes the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= SEG_BLANK;
      s2_q      <= SEG_BLANK;
      cand_q    <= SEG_BLANK;
      last_q    <= SEG_BLANK;
      cnt_q     <= 8'd0;
      digit_q   <= 4'd0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      state_q   <= IDLE;
    end else begin
      s1_q      <= seg_7;
      s2_q      <= s1_q;
      cand_q    <= cand_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
    end
  end

  assign digit     = digit_q;
  assign err       = err_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg_7_reader.sv
// Scoreboard bench for seg_7_reader: stimulus pushes expected {digit, err}, a negedge
// monitor pops and compares on every handshake. Hex expectations follow SEG7_HEX_EN.
module tb_seg_7_reader;

  typedef struct packed {
    logic [3:0] digit;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_7 = 7'b0000000;
  logic       out_ready = 1'b1;
  logic       overrun_clr = 1'b0;
  logic [3:0] digit;
  logic       out_valid;
  logic       err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int pushed = 0;
  exp_t exp_q[$];

  seg_7_reader #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_7       (seg_7),
    .out_ready   (out_ready),
    .overrun_clr (overrun_clr),
    .digit       (digit),
    .out_valid   (out_valid),
    .err         (err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_result(input logic [3:0] d, input logic e);
    exp_t x;
    x.digit = d;
    x.err   = e;
    exp_q.push_back(x);
    pushed++;
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (out_valid) break;
      tick();
    end
    check(name, out_valid, 1);
  endtask

  // Monitor: every accepted handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", out_valid, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_digit", digit, e.digit);
        check("sb_err", err, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    tick(3);
    check("rst_digit", digit, 0);
    check("rst_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    tick(2);

    // Digit 3 held: valid exactly 7 edges after driving (stable from the next edge + 6).
    seg_7 = 7'b1111001;
    expect_result(4'd3, 1'b0);
    tick(6);
    check("lat_early", out_valid, 0);
    tick();
    check("lat_on_time", out_valid, 1);
    check("lat_digit", digit, 3);
    hs0 = hs_count;
    tick(20);
    check("held_once", hs_count - hs0, 1);

    // Return to blank silently, then a 2-cycle glitch of 5 must not report.
    seg_7 = 7'b0000000;
    tick(12);
    hs0 = hs_count;
    seg_7 = 7'b1011011;
    tick(2);
    seg_7 = 7'b0000000;
    tick(15);
    check("glitch_no_valid", hs_count - hs0, 0);
    check("glitch_valid_low", out_valid, 0);

    // Pending 1 with back-pressure, overrun on change to 7, then 7 reported.
    out_ready = 1'b0;
    seg_7 = 7'b0110000;
    expect_result(4'd1, 1'b0);
    wait_valid("pend1_valid", 20);
    tick(3);
    check("pend1_hold_valid", out_valid, 1);
    check("pend1_hold_digit", digit, 1);
    seg_7 = 7'b1110000;
    expect_result(4'd7, 1'b0);
    tick(4);
    check("overrun_set", overrun, 1);
    check("pend1_still_digit", digit, 1);
    out_ready = 1'b1;
    tick();
    check("hs_valid_low", out_valid, 0);
    wait_valid("seven_valid", 20);
    check("seven_digit", digit, 7);
    tick();
    check("overrun_sticky", overrun, 1);

    // overrun_clr alone clears on the next edge.
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("overrun_cleared", overrun, 0);

    // Simultaneous set and clear: set wins.
    out_ready = 1'b0;
    seg_7 = 7'b1111111;
    expect_result(4'd8, 1'b0);
    wait_valid("pend8_valid", 20);
    check("pend8_digit", digit, 8);
    seg_7 = 7'b0110011;
    tick(4);
    check("overrun_set2", overrun, 1);
    overrun_clr = 1'b1;
    tick(2);
    check("overrun_set_wins", overrun, 1);
    overrun_clr = 1'b0;
    seg_7 = 7'b1111111;
    tick(3);

    // Asynchronous reset in PEND with digit 8 pending.
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_digit", digit, 0);
    check("arst_valid", out_valid, 0);
    check("arst_err", err, 0);
    check("arst_overrun", overrun, 0);
    exp_q.delete();
    pushed--;
    out_ready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    expect_result(4'd8, 1'b0);
    wait_valid("post_rst_valid", 12);
    check("post_rst_digit", digit, 8);
    tick();

    // Hex glyph A, digit 0, and an illegal pattern.
    seg_7 = 7'b1110111;
`ifdef SEG7_HEX_EN
    expect_result(4'd10, 1'b0);
`else
    expect_result(4'd0, 1'b1);
`endif
    wait_valid("hexa_valid", 20);
    tick();
    seg_7 = 7'b1111110;
    expect_result(4'd0, 1'b0);
    wait_valid("zero_valid", 20);
    tick();
    seg_7 = 7'b1010101;
    expect_result(4'd0, 1'b1);
    wait_valid("illegal_valid", 20);
    check("illegal_err", err, 1);
    tick(10);

    check("queue_empty", exp_q.size(), 0);
    check("handshake_count", hs_count, pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
